// File: rtl/l2dr_req_arb_if.sv
// ----------------------------------------------------------------------------
// l2dr_req_arb_if
// Purpose : one valid/retry/payload channel. A transfer happens in any cycle
//           where valid=1 and retry=0; the producer holds valid and data
//           stable until that transfer completes.
// Params  : W - payload width.
// Signals : valid (producer -> consumer)
//           retry (consumer -> producer, back-pressure)
//           data  (producer -> consumer, W bits)
// Modports: master - producer side (drives valid/data, samples retry)
//           slave  - consumer side (samples valid/data, drives retry)
// ----------------------------------------------------------------------------
interface l2dr_req_arb_if #(
    parameter int W = 64
);
    logic         valid;
    logic         retry;
    logic [W-1:0] data;

    modport master (output valid, output data, input retry);
    modport slave  (input valid, input data, output retry);
endinterface

// File: rtl/l2dr_req_arb.sv
// ----------------------------------------------------------------------------
// l2dr_req_arb
// Purpose : joins the L2 and L2TLB request streams onto the single directory
//           request channel (round-robin, 2-entry output buffer) and splits
//           the directory snack stream by nodeid parity (even -> L2,
//           odd -> L2TLB), each destination with its own 2-entry buffer.
//           A sticky flag records any accepted request whose nodeid parity
//           does not match its source.
// Ports   : clk          - clock, rising edge
//           reset        - asynchronous, active-low (0 = in reset)
//           l2_req       - slave channel, L2 requests (REQ_W)
//           tlb_req      - slave channel, L2TLB requests (REQ_W)
//           l2todr_req   - master channel, merged requests to directory
//           drtol2_snack - slave channel, snacks from directory (SNACK_W)
//           l2_snack     - master channel, even-nodeid snacks to L2
//           tlb_snack    - master channel, odd-nodeid snacks to L2TLB
//           nid_err      - sticky nodeid-parity mismatch flag
// ----------------------------------------------------------------------------

// Two-entry FIFO used for all three buffers. Pushes at count 2 and pops at
// count 0 are ignored so a misbehaving caller cannot corrupt the pointers.
module l2dr_fifo2 #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   cnt,
    output logic [W-1:0] head
);
    logic [W-1:0] mem_r [2];
    logic         wr_ptr_r;
    logic         rd_ptr_r;
    logic [1:0]   cnt_r;
    logic         push_ok_s;
    logic         pop_ok_s;

    assign push_ok_s = push & (cnt_r != 2'd2);
    assign pop_ok_s  = pop & (cnt_r != 2'd0);
    assign cnt       = cnt_r;
    assign head      = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; reset discards everything buffered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_r[0] <= {W{1'b0}};
            mem_r[1] <= {W{1'b0}};
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            cnt_r    <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_r <= cnt_r + 2'd1;
                2'b01:   cnt_r <= cnt_r - 2'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end
endmodule

module l2dr_req_arb #(
    parameter int REQ_W         = 64,
    parameter int SNACK_W       = 576,
    parameter int REQ_NID_LSB   = 0,
    parameter int SNACK_NID_LSB = 0
) (
    input  logic            clk,
    input  logic            reset,
    l2dr_req_arb_if.slave   l2_req,
    l2dr_req_arb_if.slave   tlb_req,
    l2dr_req_arb_if.master  l2todr_req,
    l2dr_req_arb_if.slave   drtol2_snack,
    l2dr_req_arb_if.master  l2_snack,
    l2dr_req_arb_if.master  tlb_snack,
    output logic            nid_err
);
    typedef enum logic {
        PRIO_L2  = 1'b0,
        PRIO_TLB = 1'b1
    } prio_e;

    // Nodeid bit 0 of a request; L2 requests must be even, L2TLB odd.
    function automatic logic req_nid_odd(input logic [REQ_W-1:0] req);
        return req[REQ_NID_LSB];
    endfunction

    // Nodeid bit 0 of a snack selects its destination buffer.
    function automatic logic snack_nid_odd(input logic [SNACK_W-1:0] snack);
        return snack[SNACK_NID_LSB];
    endfunction

    prio_e              prio_r;
    prio_e              prio_s;
    logic               rdy_r;
    logic               nid_err_r;

    logic               l2_win_s;
    logic               tlb_win_s;
    logic               reqq_full_s;
    logic               l2_retry_s;
    logic               tlb_retry_s;
    logic               l2_acc_s;
    logic               tlb_acc_s;
    logic               reqq_push_s;
    logic [REQ_W-1:0]   reqq_push_data_s;
    logic               reqq_pop_s;
    logic               nid_bad_s;
    logic [1:0]         reqq_cnt_s;
    logic [REQ_W-1:0]   reqq_head_s;

    logic               snack_to_tlb_s;
    logic               snack_sel_full_s;
    logic               snack_retry_s;
    logic               l2q_push_s;
    logic               tlbq_push_s;
    logic               l2q_pop_s;
    logic               tlbq_pop_s;
    logic [1:0]         l2q_cnt_s;
    logic [1:0]         tlbq_cnt_s;
    logic [SNACK_W-1:0] l2q_head_s;
    logic [SNACK_W-1:0] tlbq_head_s;

    // rdy_r drops asynchronously with reset so every input retry is forced
    // high for the whole reset period and rises only on the first clock edge
    // after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_r <= 1'b0;
        end else begin
            rdy_r <= 1'b1;
        end
    end

    // Round-robin priority register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio_r <= PRIO_L2;
        end else begin
            prio_r <= prio_s;
        end
    end

    // Arbitration: winner choice, per-input retry and next priority. The
    // full test uses the pre-pop count, so a full buffer never takes a push
    // even when the directory drains it in the same cycle.
    always_comb begin
        l2_win_s  = 1'b0;
        tlb_win_s = 1'b0;
        case (prio_r)
            PRIO_L2: begin
                l2_win_s  = l2_req.valid;
                tlb_win_s = tlb_req.valid & ~l2_req.valid;
            end
            PRIO_TLB: begin
                tlb_win_s = tlb_req.valid;
                l2_win_s  = l2_req.valid & ~tlb_req.valid;
            end
            default: begin
                l2_win_s  = 1'b0;
                tlb_win_s = 1'b0;
            end
        endcase

        reqq_full_s = (reqq_cnt_s == 2'd2);
        l2_retry_s  = ~rdy_r | reqq_full_s | ~l2_win_s;
        tlb_retry_s = ~rdy_r | reqq_full_s | ~tlb_win_s;
        l2_acc_s    = l2_req.valid & ~l2_retry_s;
        tlb_acc_s   = tlb_req.valid & ~tlb_retry_s;
        reqq_push_s = l2_acc_s | tlb_acc_s;
        if (l2_acc_s) begin
            reqq_push_data_s = l2_req.data;
        end else begin
            reqq_push_data_s = tlb_req.data;
        end

        // After a push the loser gets the next tie.
        prio_s = prio_r;
        if (l2_acc_s) begin
            prio_s = PRIO_TLB;
        end else if (tlb_acc_s) begin
            prio_s = PRIO_L2;
        end else begin
            prio_s = prio_r;
        end

        nid_bad_s = (l2_acc_s & req_nid_odd(l2_req.data)) |
                    (tlb_acc_s & ~req_nid_odd(tlb_req.data));
    end

    assign l2_req.retry     = l2_retry_s;
    assign tlb_req.retry    = tlb_retry_s;
    assign reqq_pop_s       = l2todr_req.valid & ~l2todr_req.retry;
    assign l2todr_req.valid = (reqq_cnt_s != 2'd0);
    assign l2todr_req.data  = reqq_head_s;

    // Sticky nodeid-parity error; the offending request is still forwarded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nid_err_r <= 1'b0;
        end else if (nid_bad_s) begin
            nid_err_r <= 1'b1;
        end else begin
            nid_err_r <= nid_err_r;
        end
    end

    assign nid_err = nid_err_r;

    l2dr_fifo2 #(.W(REQ_W)) u_reqq (
        .clk       (clk),
        .reset     (reset),
        .push      (reqq_push_s),
        .push_data (reqq_push_data_s),
        .pop       (reqq_pop_s),
        .cnt       (reqq_cnt_s),
        .head      (reqq_head_s)
    );

    // Snack steering: only the buffer the head snack targets is consulted,
    // so a full L2TLB buffer stalls the input only while an odd snack waits.
    always_comb begin
        snack_to_tlb_s = snack_nid_odd(drtol2_snack.data);
        if (snack_to_tlb_s) begin
            snack_sel_full_s = (tlbq_cnt_s == 2'd2);
        end else begin
            snack_sel_full_s = (l2q_cnt_s == 2'd2);
        end
        snack_retry_s = ~rdy_r | snack_sel_full_s;
        l2q_push_s    = drtol2_snack.valid & ~snack_retry_s & ~snack_to_tlb_s;
        tlbq_push_s   = drtol2_snack.valid & ~snack_retry_s & snack_to_tlb_s;
    end

    assign drtol2_snack.retry = snack_retry_s;
    assign l2q_pop_s          = l2_snack.valid & ~l2_snack.retry;
    assign tlbq_pop_s         = tlb_snack.valid & ~tlb_snack.retry;
    assign l2_snack.valid     = (l2q_cnt_s != 2'd0);
    assign l2_snack.data      = l2q_head_s;
    assign tlb_snack.valid    = (tlbq_cnt_s != 2'd0);
    assign tlb_snack.data     = tlbq_head_s;

    l2dr_fifo2 #(.W(SNACK_W)) u_l2q (
        .clk       (clk),
        .reset     (reset),
        .push      (l2q_push_s),
        .push_data (drtol2_snack.data),
        .pop       (l2q_pop_s),
        .cnt       (l2q_cnt_s),
        .head      (l2q_head_s)
    );

    l2dr_fifo2 #(.W(SNACK_W)) u_tlbq (
        .clk       (clk),
        .reset     (reset),
        .push      (tlbq_push_s),
        .push_data (drtol2_snack.data),
        .pop       (tlbq_pop_s),
        .cnt       (tlbq_cnt_s),
        .head      (tlbq_head_s)
    );
endmodule

// File: tb/tb_l2dr_req_arb.sv
module tb_l2dr_req_arb;
    localparam int REQ_W   = 64;
    localparam int SNACK_W = 576;

    logic clk;
    logic reset;
    logic nid_err;
    int   cyc;
    int   vectors;
    int   miscompares;

    l2dr_req_arb_if #(.W(REQ_W))   l2_req_i ();
    l2dr_req_arb_if #(.W(REQ_W))   tlb_req_i ();
    l2dr_req_arb_if #(.W(REQ_W))   l2todr_i ();
    l2dr_req_arb_if #(.W(SNACK_W)) drtol2_i ();
    l2dr_req_arb_if #(.W(SNACK_W)) l2_snack_i ();
    l2dr_req_arb_if #(.W(SNACK_W)) tlb_snack_i ();

    l2dr_req_arb #(
        .REQ_W(REQ_W), .SNACK_W(SNACK_W), .REQ_NID_LSB(0), .SNACK_NID_LSB(0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .l2_req       (l2_req_i),
        .tlb_req      (tlb_req_i),
        .l2todr_req   (l2todr_i),
        .drtol2_snack (drtol2_i),
        .l2_snack     (l2_snack_i),
        .tlb_snack    (tlb_snack_i),
        .nid_err      (nid_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [REQ_W-1:0]   exp_req [$];
    logic [SNACK_W-1:0] exp_l2s [$];
    logic [SNACK_W-1:0] exp_tlbs [$];
    logic               exp_nid_err;
    logic [REQ_W-1:0]   out_log [$];
    int                 out_cyc [$];
    logic [7:0]         snk_l2_log [$];
    logic [7:0]         snk_tlb_log [$];

    // scoreboard monitor: samples on the falling edge, before the next
    // rising edge commits the transfers it sees.
    initial begin
        logic [REQ_W-1:0]   m_req;
        logic [SNACK_W-1:0] m_snk;
        logic               m_l2a;
        logic               m_tlba;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                exp_req.delete(); exp_l2s.delete(); exp_tlbs.delete();
                exp_nid_err = 1'b0;
            end else begin
                vectors++;
                if (nid_err !== exp_nid_err) begin
                    miscompares++;
                    $display("FAIL nid_err: got %b expected %b (cyc %0d)", nid_err, exp_nid_err, cyc);
                end
                if (l2todr_i.valid === 1'b1) begin
                    vectors++;
                    if (exp_req.size() == 0) begin
                        miscompares++;
                        $display("FAIL req_stale: got valid data %h expected no valid", l2todr_i.data);
                    end else if (l2todr_i.retry === 1'b0) begin
                        m_req = exp_req.pop_front();
                        if (l2todr_i.data !== m_req) begin
                            miscompares++;
                            $display("FAIL req_data: got %h expected %h", l2todr_i.data, m_req);
                        end
                        out_log.push_back(l2todr_i.data);
                        out_cyc.push_back(cyc);
                    end
                end
                if (l2_snack_i.valid === 1'b1) begin
                    vectors++;
                    if (exp_l2s.size() == 0) begin
                        miscompares++;
                        $display("FAIL l2_snack_stale: got valid nid %0d expected no valid", l2_snack_i.data[7:0]);
                    end else if (l2_snack_i.retry === 1'b0) begin
                        m_snk = exp_l2s.pop_front();
                        if (l2_snack_i.data !== m_snk) begin
                            miscompares++;
                            $display("FAIL l2_snack_data: got nid %0d expected nid %0d", l2_snack_i.data[7:0], m_snk[7:0]);
                        end
                        snk_l2_log.push_back(l2_snack_i.data[7:0]);
                    end
                end
                if (tlb_snack_i.valid === 1'b1) begin
                    vectors++;
                    if (exp_tlbs.size() == 0) begin
                        miscompares++;
                        $display("FAIL tlb_snack_stale: got valid nid %0d expected no valid", tlb_snack_i.data[7:0]);
                    end else if (tlb_snack_i.retry === 1'b0) begin
                        m_snk = exp_tlbs.pop_front();
                        if (tlb_snack_i.data !== m_snk) begin
                            miscompares++;
                            $display("FAIL tlb_snack_data: got nid %0d expected nid %0d", tlb_snack_i.data[7:0], m_snk[7:0]);
                        end
                        snk_tlb_log.push_back(tlb_snack_i.data[7:0]);
                    end
                end
                m_l2a  = (l2_req_i.valid === 1'b1) && (l2_req_i.retry === 1'b0);
                m_tlba = (tlb_req_i.valid === 1'b1) && (tlb_req_i.retry === 1'b0);
                vectors++;
                if (m_l2a && m_tlba) begin
                    miscompares++;
                    $display("FAIL dual_accept: got 2 accepts expected at most 1");
                end
                if (m_l2a) begin
                    exp_req.push_back(l2_req_i.data);
                    if (l2_req_i.data[0]) exp_nid_err = 1'b1;
                end
                if (m_tlba) begin
                    exp_req.push_back(tlb_req_i.data);
                    if (!tlb_req_i.data[0]) exp_nid_err = 1'b1;
                end
                if ((drtol2_i.valid === 1'b1) && (drtol2_i.retry === 1'b0)) begin
                    if (drtol2_i.data[0]) exp_tlbs.push_back(drtol2_i.data);
                    else exp_l2s.push_back(drtol2_i.data);
                end
            end
        end
    end

    function automatic logic [SNACK_W-1:0] mk_snack(input logic [7:0] nid);
        logic [SNACK_W-1:0] s;
        for (int i = 0; i < SNACK_W / 32; i++) s[i*32 +: 32] = $urandom();
        s[7:0] = nid;
        return s;
    endfunction

    task automatic idle_inputs();
        l2_req_i.valid = 1'b0;  l2_req_i.data = 64'h0;
        tlb_req_i.valid = 1'b0; tlb_req_i.data = 64'h0;
        drtol2_i.valid = 1'b0;  drtol2_i.data = {SNACK_W{1'b0}};
        l2todr_i.retry = 1'b0;
        l2_snack_i.retry = 1'b0;
        tlb_snack_i.retry = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        l2_req_i.valid = 1'b1; l2_req_i.data = 64'h8;
        #2;
        vectors += 7;
        if (l2todr_i.valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid: got %b expected 0", l2todr_i.valid); end
        if (l2_snack_i.valid !== 1'b0) begin miscompares++; $display("FAIL rst_l2s_valid: got %b expected 0", l2_snack_i.valid); end
        if (tlb_snack_i.valid !== 1'b0) begin miscompares++; $display("FAIL rst_tlbs_valid: got %b expected 0", tlb_snack_i.valid); end
        if (nid_err !== 1'b0) begin miscompares++; $display("FAIL rst_nid_err: got %b expected 0", nid_err); end
        if (l2_req_i.retry !== 1'b1) begin miscompares++; $display("FAIL rst_l2_retry: got %b expected 1", l2_req_i.retry); end
        if (tlb_req_i.retry !== 1'b1) begin miscompares++; $display("FAIL rst_tlb_retry: got %b expected 1", tlb_req_i.retry); end
        if (drtol2_i.retry !== 1'b1) begin miscompares++; $display("FAIL rst_snack_retry: got %b expected 1", drtol2_i.retry); end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (l2todr_i.valid !== 1'b0) begin miscompares++; $display("FAIL rst_hold_valid: got %b expected 0", l2todr_i.valid); end
        l2_req_i.valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [REQ_W-1:0] l2p [3];
        logic [REQ_W-1:0] tlp [3];
        logic [REQ_W-1:0] seq [6];
        int li, ti, first_cyc;
        l2p = '{64'h10, 64'h12, 64'h14};
        tlp = '{64'h11, 64'h13, 64'h15};
        seq = '{64'h10, 64'h11, 64'h12, 64'h13, 64'h14, 64'h15};
        li = 0; ti = 0; first_cyc = -1;
        out_log.delete(); out_cyc.delete();
        for (int c = 0; c < 40 && out_log.size() < 6; c++) begin
            if (li < 3) begin l2_req_i.valid = 1'b1; l2_req_i.data = l2p[li]; end
            else l2_req_i.valid = 1'b0;
            if (ti < 3) begin tlb_req_i.valid = 1'b1; tlb_req_i.data = tlp[ti]; end
            else tlb_req_i.valid = 1'b0;
            @(negedge clk);
            if (l2_req_i.valid && !l2_req_i.retry) begin if (first_cyc < 0) first_cyc = cyc; li++; end
            if (tlb_req_i.valid && !tlb_req_i.retry) begin if (first_cyc < 0) first_cyc = cyc; ti++; end
            @(posedge clk); #1;
        end
        l2_req_i.valid = 1'b0; tlb_req_i.valid = 1'b0;
        vectors++;
        if (out_log.size() != 6) begin miscompares++; $display("FAIL rr_count: got %0d expected 6", out_log.size()); end
        for (int i = 0; i < 6 && i < out_log.size(); i++) begin
            vectors += 2;
            if (out_log[i] !== seq[i]) begin miscompares++; $display("FAIL rr_order[%0d]: got %h expected %h", i, out_log[i], seq[i]); end
            if (out_cyc[i] != first_cyc + 1 + i) begin miscompares++; $display("FAIL rr_cycle[%0d]: got %0d expected %0d", i, out_cyc[i], first_cyc + 1 + i); end
        end
        vectors++;
        if (nid_err !== 1'b0) begin miscompares++; $display("FAIL rr_nid_err: got %b expected 0", nid_err); end
    endtask

    task automatic test_dir_stall();
        int li;
        li = 0;
        out_log.delete(); out_cyc.delete();
        l2todr_i.retry = 1'b1;
        for (int c = 0; c < 5; c++) begin
            l2_req_i.valid = (li < 6); l2_req_i.data = 64'h30 + 64'(2 * li);
            @(negedge clk);
            if (c >= 2) begin
                vectors++;
                if (l2_req_i.retry !== 1'b1) begin miscompares++; $display("FAIL stall_retry c%0d: got %b expected 1", c, l2_req_i.retry); end
            end
            if (l2_req_i.valid && !l2_req_i.retry) li++;
            @(posedge clk); #1;
        end
        vectors++;
        if (li != 2) begin miscompares++; $display("FAIL stall_accepts: got %0d expected 2", li); end
        l2todr_i.retry = 1'b0;
        for (int c = 0; c < 40 && out_log.size() < 6; c++) begin
            l2_req_i.valid = (li < 6); l2_req_i.data = 64'h30 + 64'(2 * li);
            @(negedge clk);
            if (l2_req_i.valid && !l2_req_i.retry) li++;
            @(posedge clk); #1;
        end
        l2_req_i.valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (out_log.size() != 6) begin miscompares++; $display("FAIL stall_count: got %0d expected 6", out_log.size()); end
        for (int i = 0; i < 6 && i < out_log.size(); i++) begin
            vectors++;
            if (out_log[i] !== 64'h30 + 64'(2 * i)) begin miscompares++; $display("FAIL stall_order[%0d]: got %h expected %h", i, out_log[i], 64'h30 + 64'(2 * i)); end
        end
    endtask

    task automatic test_nid_err();
        bit done;
        done = 1'b0;
        out_log.delete(); out_cyc.delete();
        l2_req_i.valid = 1'b1; l2_req_i.data = 64'h21;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            vectors++;
            if (nid_err !== 1'b0) begin miscompares++; $display("FAIL nid_pre: got %b expected 0", nid_err); end
            if (!l2_req_i.retry) done = 1'b1;
            @(posedge clk); #1;
        end
        l2_req_i.valid = 1'b0;
        @(negedge clk);
        vectors += 2;
        if (!done) begin miscompares++; $display("FAIL nid_accept: got no accept expected accept"); end
        if (nid_err !== 1'b1) begin miscompares++; $display("FAIL nid_rise: got %b expected 1", nid_err); end
        repeat (5) @(posedge clk);
        #1;
        vectors += 2;
        if (nid_err !== 1'b1) begin miscompares++; $display("FAIL nid_sticky: got %b expected 1", nid_err); end
        if (out_log.size() != 1 || out_log[0] !== 64'h21) begin miscompares++; $display("FAIL nid_fwd: got %0d entries expected one 0x21", out_log.size()); end
    endtask

    task automatic test_snack_demux();
        logic [SNACK_W-1:0] snk [4];
        int si;
        snk[0] = mk_snack(8'd3); snk[1] = mk_snack(8'd5);
        snk[2] = mk_snack(8'd7); snk[3] = mk_snack(8'd2);
        si = 0;
        snk_l2_log.delete(); snk_tlb_log.delete();
        tlb_snack_i.retry = 1'b1; l2_snack_i.retry = 1'b0;
        for (int c = 0; c < 8; c++) begin
            drtol2_i.valid = (si < 4); drtol2_i.data = snk[(si < 4) ? si : 3];
            @(negedge clk);
            if (drtol2_i.valid && drtol2_i.data[7:0] == 8'd7) begin
                vectors++;
                if (drtol2_i.retry !== 1'b1) begin miscompares++; $display("FAIL snk_retry7: got %b expected 1", drtol2_i.retry); end
            end
            if (drtol2_i.valid && !drtol2_i.retry) si++;
            @(posedge clk); #1;
        end
        vectors += 2;
        if (si != 2) begin miscompares++; $display("FAIL snk_stall_accepts: got %0d expected 2", si); end
        if (snk_l2_log.size() != 0) begin miscompares++; $display("FAIL snk_l2_early: got %0d expected 0", snk_l2_log.size()); end
        tlb_snack_i.retry = 1'b0;
        for (int c = 0; c < 30 && !(si == 4 && snk_tlb_log.size() == 3 && snk_l2_log.size() == 1); c++) begin
            drtol2_i.valid = (si < 4); drtol2_i.data = snk[(si < 4) ? si : 3];
            @(negedge clk);
            if (drtol2_i.valid && !drtol2_i.retry) si++;
            @(posedge clk); #1;
        end
        drtol2_i.valid = 1'b0;
        vectors += 2;
        if (snk_tlb_log.size() != 3 || snk_tlb_log[0] !== 8'd3 || snk_tlb_log[1] !== 8'd5 || snk_tlb_log[2] !== 8'd7) begin
            miscompares++; $display("FAIL snk_tlb_seq: got %p expected 3,5,7", snk_tlb_log);
        end
        if (snk_l2_log.size() != 1 || snk_l2_log[0] !== 8'd2) begin
            miscompares++; $display("FAIL snk_l2_seq: got %p expected 2", snk_l2_log);
        end
    endtask

    task automatic test_reset_mid();
        int li, sent, ti;
        li = 0; sent = 0;
        l2todr_i.retry = 1'b1; l2_snack_i.retry = 1'b1;
        for (int c = 0; c < 10 && !(li == 2 && sent == 1); c++) begin
            l2_req_i.valid = (li < 2); l2_req_i.data = 64'h40 + 64'(2 * li);
            drtol2_i.valid = (sent < 1); drtol2_i.data = mk_snack(8'd4);
            @(negedge clk);
            if (l2_req_i.valid && !l2_req_i.retry) li++;
            if (drtol2_i.valid && !drtol2_i.retry) sent++;
            @(posedge clk); #1;
        end
        l2_req_i.valid = 1'b0; drtol2_i.valid = 1'b0;
        vectors += 2;
        if (l2todr_i.valid !== 1'b1) begin miscompares++; $display("FAIL rm_pre_req: got %b expected 1", l2todr_i.valid); end
        if (l2_snack_i.valid !== 1'b1) begin miscompares++; $display("FAIL rm_pre_l2s: got %b expected 1", l2_snack_i.valid); end
        #2;
        reset = 1'b0;
        #1;
        vectors += 5;
        if (l2todr_i.valid !== 1'b0) begin miscompares++; $display("FAIL rm_req_valid: got %b expected 0", l2todr_i.valid); end
        if (l2_snack_i.valid !== 1'b0) begin miscompares++; $display("FAIL rm_l2s_valid: got %b expected 0", l2_snack_i.valid); end
        if (tlb_snack_i.valid !== 1'b0) begin miscompares++; $display("FAIL rm_tlbs_valid: got %b expected 0", tlb_snack_i.valid); end
        if (nid_err !== 1'b0) begin miscompares++; $display("FAIL rm_nid_err: got %b expected 0", nid_err); end
        if (drtol2_i.retry !== 1'b1) begin miscompares++; $display("FAIL rm_snack_retry: got %b expected 1", drtol2_i.retry); end
        @(posedge clk); #3;
        reset = 1'b1;
        l2todr_i.retry = 1'b0; l2_snack_i.retry = 1'b0;
        out_log.delete(); out_cyc.delete();
        li = 0; ti = 0;
        for (int c = 0; c < 20 && !(li == 1 && ti == 1); c++) begin
            l2_req_i.valid = (li < 1); l2_req_i.data = 64'h50;
            tlb_req_i.valid = (ti < 1); tlb_req_i.data = 64'h51;
            @(negedge clk);
            if (l2_req_i.valid && !l2_req_i.retry) li++;
            if (tlb_req_i.valid && !tlb_req_i.retry) ti++;
            @(posedge clk); #1;
        end
        l2_req_i.valid = 1'b0; tlb_req_i.valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors += 3;
        if (out_log.size() != 2) begin miscompares++; $display("FAIL rm_count: got %0d expected 2", out_log.size()); end
        else begin
            if (out_log[0] !== 64'h50) begin miscompares++; $display("FAIL rm_first: got %h expected 50", out_log[0]); end
            if (out_log[1] !== 64'h51) begin miscompares++; $display("FAIL rm_second: got %h expected 51", out_log[1]); end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (l2todr_i.valid !== 1'b0 || l2_snack_i.valid !== 1'b0) begin
                miscompares++; $display("FAIL rm_idle: got req %b l2s %b expected 0 0", l2todr_i.valid, l2_snack_i.valid);
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        exp_nid_err = 1'b0;
        test_reset();
        test_round_robin();
        test_dir_stall();
        test_snack_demux();
        test_nid_err();
        test_reset_mid();
        vectors += 3;
        if (exp_req.size() != 0) begin miscompares++; $display("FAIL end_req_q: got %0d left expected 0", exp_req.size()); end
        if (exp_l2s.size() != 0) begin miscompares++; $display("FAIL end_l2s_q: got %0d left expected 0", exp_l2s.size()); end
        if (exp_tlbs.size() != 0) begin miscompares++; $display("FAIL end_tlbs_q: got %0d left expected 0", exp_tlbs.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/l2dr_req_arb.md
Name: l2dr_req_arb

Overview:
- Sits inside the l2cache between the L2 pipeline, the l2tlb, and the single directory port.
- Merges L2 and L2TLB request streams onto one l2todr_req channel using round-robin arbitration with a 2-entry output buffer.
- Demultiplexes drtol2_snack by nodeid parity: even nodeid goes to the L2, odd nodeid goes to the L2TLB.
- Flags requests whose nodeid parity does not match their source.

Parameters:
- REQ_W, 64, width of the packed request payload.
- SNACK_W, 576, width of the packed snack payload.
- REQ_NID_LSB, 0, bit position of nodeid bit 0 inside the request payload.
- SNACK_NID_LSB, 0, bit position of nodeid bit 0 inside the snack payload.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- l2_req_valid  in  1  L2 request valid.
- l2_req_retry  out  1  back-pressure to L2.
- l2_req  in  REQ_W  L2 request payload.
- tlb_req_valid  in  1  L2TLB request valid.
- tlb_req_retry  out  1  back-pressure to L2TLB.
- tlb_req  in  REQ_W  L2TLB request payload.
- l2todr_req_valid  out  1  merged request valid.
- l2todr_req_retry  in  1  directory back-pressure.
- l2todr_req  out  REQ_W  merged request payload.
- drtol2_snack_valid  in  1  snack valid from directory.
- drtol2_snack_retry  out  1  back-pressure to directory.
- drtol2_snack  in  SNACK_W  snack payload.
- l2_snack_valid  out  1  snack valid to L2.
- l2_snack_retry  in  1  L2 back-pressure.
- l2_snack  out  SNACK_W  snack payload to L2.
- tlb_snack_valid  out  1  snack valid to L2TLB.
- tlb_snack_retry  in  1  L2TLB back-pressure.
- tlb_snack  out  SNACK_W  snack payload to L2TLB.
- nid_err  out  1  sticky nodeid-parity mismatch flag.

Behaviour:
- Handshake rule, all channels: a transfer occurs in a cycle where valid=1 and retry=0. A producer holds valid and payload stable until the transfer completes.
- Reset (reset=0, asynchronous):
  - all FIFOs empty; all *_valid=0; nid_err=0; prio=L2.
  - l2_req_retry, tlb_req_retry and drtol2_snack_retry = 1 while reset is asserted.
  - In-flight buffered entries are discarded.
- Request path:
  - Output FIFO holds 2 entries (reqq). l2todr_req_valid = (reqq count != 0). l2todr_req = head entry.
  - Head pops when l2todr_req_valid=1 and l2todr_req_retry=0.
  - Winner selection:
    - only one input valid: that input wins;
    - both valid: the input named by prio wins;
    - neither valid: no winner.
  - Retry per input: retry_x = (reqq count==2) OR (x is not the winner).
    - Count is the pre-pop value: no push at count 2, even if a pop happens in the same cycle.
  - A simultaneous push and pop at count 1 leaves count at 1.
  - Latency: a request accepted in cycle N is visible on l2todr_req in cycle N+1 at the earliest.
  - Ordering is FIFO across both sources.
  - prio update: after any accepted push, prio = the non-winning source. prio is unchanged when nothing is pushed.
- nid_err:
  - Set the cycle after an accepted L2 request has payload[REQ_NID_LSB]=1, or an accepted L2TLB request has payload[REQ_NID_LSB]=0.
  - The offending request is still forwarded unchanged.
  - Cleared only by reset.
- Snack path:
  - Two 2-entry FIFOs: l2q and tlbq.
  - Destination = drtol2_snack[SNACK_NID_LSB]: 0 selects l2q, 1 selects tlbq.
  - drtol2_snack_retry = (count of the selected destination FIFO == 2), using the pre-pop value.
  - x_snack_valid = (xq nonempty). xq pops when x_snack_valid=1 and x_snack_retry=0.
  - Each destination drains independently: a stalled L2TLB does not block even-nodeid snacks once they are accepted.
  - A blocked head snack at the input does block later snacks (no reordering at the input).
- Payloads are passed bit-exact; there are no width changes.
- Steady-state throughput: 1 request per cycle and 1 snack per cycle per destination when there is no back-pressure.

Test Plan:
- Round-robin fairness:
  - Stimulus: both requesters valid continuously, retry=0, L2 payloads 0x10,0x12,0x14, L2TLB payloads 0x11,0x13,0x15.
  - Required: l2todr_req sequence 0x10,0x11,0x12,0x13,0x14,0x15 on consecutive cycles starting 1 cycle after the first accept; nid_err stays 0.
- Directory stall:
  - Stimulus: l2todr_req_retry=1 held for 5 cycles with L2 streaming.
  - Required: exactly 2 requests accepted, then l2_req_retry=1. After release, the 2 buffered requests drain in order, then streaming resumes with no loss or duplication.
- Parity error:
  - Stimulus: L2 sends payload 0x21 (nodeid bit0=1).
  - Required: request forwarded as 0x21; nid_err rises the next cycle and stays 1 until reset.
- Snack demux with independent stall:
  - Stimulus: tlb_snack_retry=1; directory sends snacks with nodeid 3, 5, 7, 2.
  - Required: tlbq fills with 3 and 5; drtol2_snack_retry=1 while nodeid 7 is at the input, so snack 2 is not accepted. After tlb_snack_retry drops, the L2TLB receives 3, 5, 7 and the L2 receives 2.
- Reset mid-operation:
  - Stimulus: assert reset=0 asynchronously with reqq holding 2 entries and l2q holding 1 entry.
  - Required: all valids drop immediately (no clock edge needed); after release, no stale entry ever appears and prio=L2, so with both requesters valid L2 wins first.
